frame_demultiplexer: RTL and testbench
======================================

# frame_demultiplexer

Registered 1-to-4 demultiplexer and frame assembler, the receive-side counterpart of the 4:1 multiplexer. Each valid beat on a single input lane is steered by `{addr1,addr0}` into one of four staging registers. Once all four lanes of a frame are filled, the block publishes them together on `out0`..`out3` and pulses `frame_valid`. It sits downstream of a muxed/serialised link and rebuilds the parallel word the multiplexer consumed.

## Interface
- `WIDTH`, default 1: data bits per lane.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  beat qualifier; `in_data` is accepted on every clock edge where it is high
- `in_data`  in  WIDTH  lane payload
- `addr0`  in  1  lane select LSB
- `addr1`  in  1  lane select MSB; lane = `{addr1,addr0}`, so `addr0=1,addr1=0` selects lane 1
- `sync`  in  1  start-of-frame; discards any partial frame
- `out0`..`out3`  out  WIDTH each  last completed frame, registered
- `frame_valid`  out  1  one-cycle pulse when `out0`..`out3` update
- `lane_strobe`  out  4  one-hot, registered; bit n pulses the cycle after lane n is written
- `overrun`  out  1  sticky; a lane was written twice within one frame

## Operation
- Internal state: staging regs `stage0`..`stage3`, fill mask `mask[3:0]`, and an auto-address counter `cnt[1:0]` (configuration-dependent).
- Derived states:
  - EMPTY: `mask==0`.
  - FILLING: `mask!=0` and `mask!=4'b1111`.
  - The all-ones mask is never held. Completion is resolved on the same edge.
- Accepted beat (`in_valid=1`) with lane L:
  - `stageL <= in_data`.
  - `lane_strobe <= 1<<L`; otherwise `lane_strobe <= 0`.
  - If `mask[L]` is already 1: `overrun <= 1`, the data overwrites, and the mask is unchanged.
  - Define `next_mask = mask | (1<<L)`.
- Completion, when `next_mask==4'b1111`:
  - `outN <=` the staging values, with the current beat substituted for lane L.
  - `frame_valid <= 1` and `mask <= 0`.
  - Outputs change only at completion; all four update on the same edge.
- No completion: `mask <= next_mask` and `frame_valid <= 0`.
- `sync=1`:
  - The mask is treated as 0 before applying any beat in the same cycle. The partial frame is discarded, and stage contents are don't-care.
  - `sync` with `in_valid` makes that beat the first beat of the new frame.
  - `sync` does not clear `overrun`.
- `in_valid=0`:
  - Mask, stage and outputs hold.
  - `frame_valid` and `lane_strobe` return to 0.
  - `addr`/`in_data` are ignored, including X values.
- Lanes may arrive in any order. Back-to-back frames at one beat per cycle are supported with no bubble.

## Timing
- Reset (synchronous, dominates all inputs):
  - `out0`..`out3` = 0, `frame_valid` = 0, `lane_strobe` = 0, `overrun` = 0.
  - `mask` = 0, `cnt` = 0, stage regs = 0.
- Reset asserted mid-frame discards the partial frame. The first beat after reset is lane data for a fresh frame.
- Latency:
  - Completing beat sampled at edge k produces `frame_valid` = 1 and new `outN` visible after edge k, valid through cycle k+1.
  - `lane_strobe` has the same latency.
- `frame_valid` is never high for two consecutive cycles. The minimum frame is 4 beats.
- Throughput: one frame per 4 cycles maximum.

## Configuration
- `FRAME_DEMUX_AUTO_ADDR_EN` defined:
  - Lane = `cnt`. `addr0`/`addr1` are ignored.
  - `cnt` increments on each accepted beat and wraps 3→0.
  - `sync` forces lane 0 for a coincident beat (then `cnt <= 1`), else `cnt <= 0`.
  - `overrun` is tied 0.
- Not defined: lane = `{addr1,addr0}` exactly as above. `cnt` is absent.

## Test plan
- Reset, then four beats on lanes 0,1,2,3 with data 1,0,1,1 (WIDTH=1) → `frame_valid` pulses once after the 4th edge; `out0..3`=1,0,1,1; `lane_strobe` sequence 0001,0010,0100,1000.
- Out-of-order lanes 3,1,0,2 with data A,B,C,D (WIDTH=4) → `out0`=C, `out1`=B, `out2`=D, `out3`=A; no overrun.
- Lanes 0,0,1,2,3 with data 5,6,7,8,9 → `overrun`=1 after 2nd beat and stays 1; frame emits `out0`=6.
- Lanes 0,1, then `sync` with a beat on lane 2, then lanes 0,1,3 → exactly one `frame_valid`, after the 6th beat, with the post-sync data; `reset` mid-frame → all outputs 0 and the next 4 beats form a frame.
- `in_valid`=0 with X on `in_data`/`addr` between beats → outputs and mask unchanged, no X on outputs.
- With `FRAME_DEMUX_AUTO_ADDR_EN`: 8 consecutive beats 1..8 with `addr` held at 3 → two frames: (1,2,3,4) then (5,6,7,8); `frame_valid` after beats 4 and 8.

Source files
------------

// File: rtl/frame_demultiplexer_if.sv
// frame_demultiplexer_if: lane-beat input and assembled-frame output bundle for frame_demultiplexer.
interface frame_demultiplexer_if #(parameter int WIDTH = 1);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             addr0;
    logic             addr1;
    logic             sync;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic             frame_valid;
    logic [3:0]       lane_strobe;
    logic             overrun;
    modport master (
        output in_valid, in_data, addr0, addr1, sync,
        input  out0, out1, out2, out3, frame_valid, lane_strobe, overrun
    );
    modport slave (
        input  in_valid, in_data, addr0, addr1, sync,
        output out0, out1, out2, out3, frame_valid, lane_strobe, overrun
    );
endinterface

// File: rtl/frame_demultiplexer.sv
// frame_demultiplexer: steers lane beats into four staging regs and publishes a full frame at once.
// Define FRAME_DEMUX_AUTO_ADDR_EN to take the lane from an internal counter instead of addr1/addr0.
module frame_demultiplexer #(
    parameter int WIDTH = 1
) (
    input logic                 clk,
    input logic                 reset,
    frame_demultiplexer_if.slave bus
);
    logic [WIDTH-1:0] stage_q [4];
    logic [WIDTH-1:0] stage_d [4];
    logic [WIDTH-1:0] out_q [4];
    logic [WIDTH-1:0] out_d [4];
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       strobe_q, strobe_d;
    logic             fv_q, fv_d;
    logic             ovr_q, ovr_d;
    logic [1:0]       lane;
    logic [3:0]       cur_mask;
    logic [3:0]       next_mask;
`ifdef FRAME_DEMUX_AUTO_ADDR_EN
    logic [1:0]       cnt_q, cnt_d;
    logic             unused_addr;
    assign unused_addr = bus.addr0 ^ bus.addr1;
    assign lane = bus.sync ? 2'd0 : cnt_q;
    assign cnt_d = bus.in_valid ? lane + 2'd1 : (bus.sync ? 2'd0 : cnt_q);
`else
    assign lane = {bus.addr1, bus.addr0};
`endif
    // sync discards the partial frame before the coincident beat is applied
    assign cur_mask  = bus.sync ? 4'b0000 : mask_q;
    assign next_mask = cur_mask | (4'b0001 << lane);
    always_comb begin
        stage_d  = stage_q;
        out_d    = out_q;
        mask_d   = cur_mask;
        strobe_d = 4'b0000;
        fv_d     = 1'b0;
        ovr_d    = ovr_q;
        if (bus.in_valid) begin
            stage_d[lane] = bus.in_data;
            strobe_d      = 4'b0001 << lane;
`ifdef FRAME_DEMUX_AUTO_ADDR_EN
            ovr_d         = 1'b0;
`else
            ovr_d         = ovr_q | cur_mask[lane];
`endif
            if (next_mask == 4'b1111) begin
                out_d  = stage_d;
                fv_d   = 1'b1;
                mask_d = 4'b0000;
            end else begin
                mask_d = next_mask;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q  <= '{default: '0};
            out_q    <= '{default: '0};
            mask_q   <= 4'b0000;
            strobe_q <= 4'b0000;
            fv_q     <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef FRAME_DEMUX_AUTO_ADDR_EN
            cnt_q    <= 2'd0;
`endif
        end else begin
            stage_q  <= stage_d;
            out_q    <= out_d;
            mask_q   <= mask_d;
            strobe_q <= strobe_d;
            fv_q     <= fv_d;
            ovr_q    <= ovr_d;
`ifdef FRAME_DEMUX_AUTO_ADDR_EN
            cnt_q    <= cnt_d;
`endif
        end
    end
    assign bus.out0        = out_q[0];
    assign bus.out1        = out_q[1];
    assign bus.out2        = out_q[2];
    assign bus.out3        = out_q[3];
    assign bus.frame_valid = fv_q;
    assign bus.lane_strobe = strobe_q;
    assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_frame_demultiplexer.sv
// tb_frame_demultiplexer: directed test-plan steps plus random beats against a frame-level reference model.
module tb_frame_demultiplexer;
    localparam int W = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    frame_demultiplexer_if #(.WIDTH(W)) bus ();
    frame_demultiplexer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    logic [W-1:0] m_stage [4];
    logic [W-1:0] m_out [4];
    bit           have [4];
    bit           m_fv;
    logic [3:0]   m_strobe;
    bit           m_ovr;
`ifdef FRAME_DEMUX_AUTO_ADDR_EN
    int           m_cnt;
`endif
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic check_all();
        chk("out0", bus.out0, m_out[0]);
        chk("out1", bus.out1, m_out[1]);
        chk("out2", bus.out2, m_out[2]);
        chk("out3", bus.out3, m_out[3]);
        chk("frame_valid", {3'b0, bus.frame_valid}, {3'b0, m_fv});
        chk("lane_strobe", bus.lane_strobe, m_strobe);
        chk("overrun", {3'b0, bus.overrun}, {3'b0, m_ovr});
    endtask
    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_stage[i] = '0;
            m_out[i]   = '0;
            have[i]    = 1'b0;
        end
        m_fv = 0;
        m_strobe = 4'b0;
        m_ovr = 0;
`ifdef FRAME_DEMUX_AUTO_ADDR_EN
        m_cnt = 0;
`endif
    endtask
    task automatic model_step(input bit v, input int l, input logic [W-1:0] d, input bit s);
        int lane;
        if (s) begin
            for (int i = 0; i < 4; i++) have[i] = 1'b0;
`ifdef FRAME_DEMUX_AUTO_ADDR_EN
            m_cnt = 0;
`endif
        end
`ifdef FRAME_DEMUX_AUTO_ADDR_EN
        lane = m_cnt;
`else
        lane = l;
`endif
        m_fv = 0;
        m_strobe = 4'b0;
        if (v) begin
`ifndef FRAME_DEMUX_AUTO_ADDR_EN
            if (have[lane]) m_ovr = 1;
`else
            m_cnt = (m_cnt + 1) % 4;
`endif
            have[lane] = 1'b1;
            m_stage[lane] = d;
            m_strobe[lane] = 1'b1;
            if (have[0] && have[1] && have[2] && have[3]) begin
                for (int i = 0; i < 4; i++) begin
                    m_out[i] = m_stage[i];
                    have[i] = 1'b0;
                end
                m_fv = 1;
            end
        end
    endtask
    task automatic step(input bit v, input int l, input logic [W-1:0] d, input bit s);
        bus.in_valid = v;
        bus.sync     = s;
        bus.in_data  = v ? d : 'x;
        {bus.addr1, bus.addr0} = v ? 2'(l) : 2'bxx;
        @(posedge clk);
        #1;
        model_step(v, l, d, s);
        check_all();
    endtask
    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.sync = 1'b0;
        bus.in_data = 4'hF;
        {bus.addr1, bus.addr0} = 2'd3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_all();
    endtask
    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(3) != 0, int'($urandom_range(3)), W'($urandom), $urandom_range(7) == 0);
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.sync = 1'b0;
        bus.in_data = '0;
        {bus.addr1, bus.addr0} = 2'd0;
        model_reset();
        do_reset();
        chk("reset_out0", bus.out0, 4'h0);
`ifndef FRAME_DEMUX_AUTO_ADDR_EN
        step(1, 0, 4'h1, 0);
        chk("t1_strobe0", bus.lane_strobe, 4'b0001);
        step(1, 1, 4'h0, 0);
        step(1, 2, 4'h1, 0);
        step(1, 3, 4'h1, 0);
        chk("t1_fv", {3'b0, bus.frame_valid}, 4'h1);
        chk("t1_strobe3", bus.lane_strobe, 4'b1000);
        chk("t1_out1", bus.out1, 4'h0);
        chk("t1_out3", bus.out3, 4'h1);
        step(0, 0, 4'h0, 0);
        chk("t1_fv_drop", {3'b0, bus.frame_valid}, 4'h0);
        step(1, 3, 4'hA, 0);
        step(0, 0, 4'h0, 0);
        step(1, 1, 4'hB, 0);
        step(1, 0, 4'hC, 0);
        step(0, 0, 4'h0, 0);
        step(1, 2, 4'hD, 0);
        chk("t2_out0", bus.out0, 4'hC);
        chk("t2_out1", bus.out1, 4'hB);
        chk("t2_out2", bus.out2, 4'hD);
        chk("t2_out3", bus.out3, 4'hA);
        chk("t2_ovr", {3'b0, bus.overrun}, 4'h0);
        step(1, 0, 4'h5, 0);
        step(1, 0, 4'h6, 0);
        chk("t3_ovr", {3'b0, bus.overrun}, 4'h1);
        step(1, 1, 4'h7, 0);
        step(1, 2, 4'h8, 0);
        step(1, 3, 4'h9, 0);
        chk("t3_out0", bus.out0, 4'h6);
        chk("t3_ovr_sticky", {3'b0, bus.overrun}, 4'h1);
        do_reset();
        step(1, 0, 4'h1, 0);
        step(1, 1, 4'h2, 0);
        step(1, 2, 4'h3, 1);
        step(1, 0, 4'h4, 0);
        step(1, 1, 4'h5, 0);
        chk("t4_no_fv", {3'b0, bus.frame_valid}, 4'h0);
        step(1, 3, 4'h6, 0);
        chk("t4_fv", {3'b0, bus.frame_valid}, 4'h1);
        chk("t4_out2", bus.out2, 4'h3);
        step(1, 0, 4'h7, 0);
        step(1, 1, 4'h8, 0);
        do_reset();
        chk("t5_out2_cleared", bus.out2, 4'h0);
        step(1, 2, 4'h9, 0);
        step(1, 3, 4'hA, 0);
        step(1, 0, 4'hB, 0);
        step(1, 1, 4'hC, 0);
        chk("t5_fv", {3'b0, bus.frame_valid}, 4'h1);
        chk("t5_out1", bus.out1, 4'hC);
`else
        for (int i = 1; i <= 8; i++) begin
            step(1, 3, 4'(i), 0);
            if (i == 4) begin
                chk("auto_fv1", {3'b0, bus.frame_valid}, 4'h1);
                chk("auto_f1_out0", bus.out0, 4'h1);
                chk("auto_f1_out3", bus.out3, 4'h4);
            end
        end
        chk("auto_fv2", {3'b0, bus.frame_valid}, 4'h1);
        chk("auto_f2_out0", bus.out0, 4'h5);
        chk("auto_f2_out2", bus.out2, 4'h7);
        chk("auto_ovr", {3'b0, bus.overrun}, 4'h0);
`endif
        random_steps(400);
        do_reset();
        random_steps(200);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
